ads_sample_fifo_axil: RTL and testbench
=======================================

// Module: ads_sample_fifo_axil
// PURPOSE
//  Buffers signed ADC samples from the ADS1675 serial receiver (data/valid pulse) in an on-chip FIFO.
//  Exposes them to the PS over AXI4-Lite: pop-on-read data register, level/status, IRQ threshold, control.
//  Raises a level-sensitive interrupt to the PS7 IRQ_F2P input once the fill level reaches the threshold.
// PARAMETERS
//  DW      24    sample width from receiver; sign-extended to 32 bits on read (DW <= 32)
//  DEPTH   1024  FIFO entries, power of two; LW = $clog2(DEPTH)
//  AW      6     AXI4-Lite address width (byte addressed, word-aligned registers)
// PORTS
//  aclk           in   1      system clock; receiver and AXI share it
//  areset         in   1      asynchronous, active-high reset
//  s_data         in   DW     signed sample from receiver
//  s_valid        in   1      one-cycle strobe, s_data valid
//  s_axi_awaddr   in   AW     | s_axi_awvalid in 1 | s_axi_awready out 1
//  s_axi_wdata    in   32     | s_axi_wstrb in 4   | s_axi_wvalid in 1 | s_axi_wready out 1
//  s_axi_bresp    out  2      | s_axi_bvalid out 1 | s_axi_bready in 1
//  s_axi_araddr   in   AW     | s_axi_arvalid in 1 | s_axi_arready out 1
//  s_axi_rdata    out  32     | s_axi_rresp out 2  | s_axi_rvalid out 1 | s_axi_rready in 1
//  irq            out  1      level interrupt
// BEHAVIOUR
//  Reset: all ready/valid outputs 0, rdata 0, resp 0, irq 0; CTRL=0, THRESH=0, pointers/level/sticky 0.
//  Registers: 0x00 DATA RO (pop) | 0x04 STATUS {ovf[31],unf[30],level[LW:0]}, W1C on [31:30]
//    | 0x0C THRESH RW [LW:0] | 0x20 CTRL RW {flush[1] self-clearing, capture_en[0]} | others read 0, write ignored.
//  Push: s_valid && capture_en && !full -> write mem[wr_ptr], wr_ptr++ (wraps mod DEPTH).
//    s_valid && capture_en && full -> sample dropped, ovf sticky set. capture_en=0 -> s_valid ignored.
//  Write channel: awready=wready=1 in the same cycle only when awvalid && wvalid && !bvalid; the register
//    updates in the handshake cycle; bvalid asserted the next cycle, held until bready; bresp=OKAY always.
//  Read channel: arready=1 when arvalid && !rvalid; rdata registered, rvalid the next cycle, held until
//    rready; rresp=OKAY always. Only one outstanding read and one outstanding write.
//  DATA read: non-empty -> rdata = sign-extended mem[rd_ptr]; pop (rd_ptr++) in the AR handshake cycle.
//    Empty -> rdata=0, no pop, unf sticky set. Read latency 1 cycle, synchronous BRAM-style read.
//  Level: tracked as LW+1 bits, 0..DEPTH; full = level==DEPTH; empty = level==0.
//    Push and pop in the same cycle: level unchanged, both succeed, even when full.
//  Flush: CTRL write with bit1=1 clears pointers, level, ovf and unf in the next cycle.
//    A flush cycle that coincides with a push or pop is dominated by the flush. Bit1 always reads 0.
//  irq = registered (THRESH!=0 && level>=THRESH); deasserts the cycle after level drops below THRESH.
//  STATUS W1C and a simultaneous new overflow in the same cycle: set wins.
//  areset asserted mid-transaction: immediate return to the reset state; pending b/r responses are lost.
// CONFIGURATION
//  ADS_FIFO_DROPCNT_EN defined: adds reg 0x10 DROPCNT RO, a 32-bit count of dropped samples (full or
//    capture disabled while s_valid). Saturates at 0xFFFF_FFFF; cleared by flush and reset.
//  ADS_FIFO_DROPCNT_EN undefined: 0x10 reads 0, no counter logic.
// TESTING
//  Reset; CTRL=1, THRESH=512; push 511 samples -> irq=0, STATUS level=511; push 1 more -> irq=1 next cycle.
//  Push 0x800001, 0x7FFFFF; read 0x00 twice -> 0xFF800001 then 0x007FFFFF; level returns to 0.
//  Empty FIFO read 0x00 -> rdata=0, STATUS[30]=1; write 0x4000_0000 to 0x04 -> STATUS[30]=0.
//  Fill to DEPTH, push 3 more -> ovf=1, level=DEPTH; with DROPCNT_EN, 0x10 reads 3.
//  Full FIFO, simultaneous s_valid and DATA pop -> level stays DEPTH, no ovf; CTRL=0x3 -> level 0, irq=0.
//  Assert areset with rvalid pending and level=100 -> rvalid=0, level=0, CTRL=0 immediately.

Source files
------------

// File: rtl/ads_sample_fifo_axil_if.sv
// AXI4-Lite slave bus bundle for the ADS sample FIFO; master drives requests, slave responds.
interface ads_sample_fifo_axil_if #(
    parameter int unsigned AW = 6
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/ads_sample_fifo_axil.sv
// ADC sample FIFO with AXI4-Lite register access and level-threshold interrupt.
// Optional drop counter at 0x10 enabled by defining ADS_FIFO_DROPCNT_EN.
module ads_sample_fifo_axil #(
    parameter int unsigned DW    = 24,
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 6
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DW-1:0]         s_data,
    input  logic                  s_valid,
    ads_sample_fifo_axil_if.slave s_axi,
    output logic                  irq
);
    localparam int unsigned LW = $clog2(DEPTH);

    localparam logic [AW-3:0] RegData    = (AW-2)'(0);
    localparam logic [AW-3:0] RegStatus  = (AW-2)'(1);
    localparam logic [AW-3:0] RegThresh  = (AW-2)'(3);
    localparam logic [AW-3:0] RegDropcnt = (AW-2)'(4);
    localparam logic [AW-3:0] RegCtrl    = (AW-2)'(8);
    localparam logic [LW:0]   FullLevel  = (LW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] mem_rd_q;
    logic [LW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LW:0]   level_q, thresh_q;
    logic          ovf_q, unf_q, cap_en_q, flush_q, irq_q;
    logic          bvalid_q, rvalid_q, rd_data_sel_q;
    logic [31:0]   rdata_reg_q;

    logic          full, empty, wr_hs, ar_hs;
    logic          wr_ctrl, wr_status, wr_thresh, rd_data, push, pop, drop_full;
    logic          clr_ovf, clr_unf;
    logic [AW-3:0] aw_word, ar_word;
    logic [31:0]   ctrl_w, thresh_w, rd_mux;
    logic          unused_addr_lsb;

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] nxt,
                                          input logic [3:0] strb);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = nxt[8*b +: 8];
        end
        return res;
    endfunction

    assign full    = (level_q == FullLevel);
    assign empty   = (level_q == '0);
    assign wr_hs   = s_axi.awvalid && s_axi.wvalid && !bvalid_q;
    assign ar_hs   = s_axi.arvalid && !rvalid_q;
    assign aw_word = s_axi.awaddr[AW-1:2];
    assign ar_word = s_axi.araddr[AW-1:2];
    assign unused_addr_lsb = ^{s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign wr_ctrl   = wr_hs && (aw_word == RegCtrl);
    assign wr_status = wr_hs && (aw_word == RegStatus);
    assign wr_thresh = wr_hs && (aw_word == RegThresh);
    assign rd_data   = ar_hs && (ar_word == RegData);

    // A pending flush swallows any push or pop in the same cycle.
    assign pop       = rd_data && !empty && !flush_q;
    assign push      = s_valid && cap_en_q && (!full || pop) && !flush_q;
    assign drop_full = s_valid && cap_en_q && full && !pop && !flush_q;

    assign ctrl_w   = merge({31'd0, cap_en_q}, s_axi.wdata, s_axi.wstrb);
    assign thresh_w = merge(32'(thresh_q), s_axi.wdata, s_axi.wstrb);
    assign clr_ovf  = wr_status && s_axi.wstrb[3] && s_axi.wdata[31];
    assign clr_unf  = wr_status && s_axi.wstrb[3] && s_axi.wdata[30];

`ifdef ADS_FIFO_DROPCNT_EN
    logic [31:0] dropcnt_q;
    logic        drop_any;

    assign drop_any = s_valid && !flush_q && (!cap_en_q || (full && !pop));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            dropcnt_q <= '0;
        end else if (flush_q) begin
            dropcnt_q <= '0;
        end else if (drop_any && (dropcnt_q != '1)) begin
            dropcnt_q <= dropcnt_q + 32'd1;
        end
    end
`endif

    // DATA is not decoded here; its value comes from the memory read register.
    always_comb begin
        rd_mux = '0;
        case (ar_word)
            RegStatus: begin
                rd_mux[31]   = ovf_q;
                rd_mux[30]   = unf_q;
                rd_mux[LW:0] = level_q;
            end
            RegThresh: rd_mux[LW:0] = thresh_q;
            RegCtrl:   rd_mux[0]    = cap_en_q;
`ifdef ADS_FIFO_DROPCNT_EN
            RegDropcnt: rd_mux = dropcnt_q;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr_q] <= s_data;
        if (pop)  mem_rd_q      <= mem[rd_ptr_q];
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            bvalid_q      <= 1'b0;
            rvalid_q      <= 1'b0;
            rd_data_sel_q <= 1'b0;
            rdata_reg_q   <= '0;
            cap_en_q      <= 1'b0;
            flush_q       <= 1'b0;
            thresh_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            irq_q         <= 1'b0;
        end else begin
            if (wr_hs)             bvalid_q <= 1'b1;
            else if (s_axi.bready) bvalid_q <= 1'b0;
            if (ar_hs)             rvalid_q <= 1'b1;
            else if (s_axi.rready) rvalid_q <= 1'b0;

            if (ar_hs) begin
                rd_data_sel_q <= pop;
                rdata_reg_q   <= rd_mux;
            end

            flush_q <= wr_ctrl && ctrl_w[1];
            if (wr_ctrl)   cap_en_q <= ctrl_w[0];
            if (wr_thresh) thresh_q <= thresh_w[LW:0];

            if (flush_q) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + LW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + LW'(1);
                if (push && !pop)      level_q <= level_q + (LW+1)'(1);
                else if (pop && !push) level_q <= level_q - (LW+1)'(1);
                // A new event beats a simultaneous write-one-to-clear.
                if (drop_full)    ovf_q <= 1'b1;
                else if (clr_ovf) ovf_q <= 1'b0;
                if (rd_data && empty) unf_q <= 1'b1;
                else if (clr_unf)     unf_q <= 1'b0;
            end

            irq_q <= (thresh_q != '0) && (level_q >= thresh_q);
        end
    end

    assign s_axi.awready = wr_hs;
    assign s_axi.wready  = wr_hs;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.arready = ar_hs;
    assign s_axi.rresp   = 2'b00;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rdata   = rd_data_sel_q ? 32'($signed(mem_rd_q)) : rdata_reg_q;
    assign irq           = irq_q;
endmodule

// File: tb/tb_ads_sample_fifo_axil.sv
// Self-checking bench for ads_sample_fifo_axil against a queue-based reference model.
module tb_ads_sample_fifo_axil;
    localparam int unsigned DW    = 24;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 6;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          irq;

    ads_sample_fifo_axil_if #(.AW(AW)) s_axi ();

    ads_sample_fifo_axil #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .aclk    (aclk),
        .areset  (areset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_axi   (s_axi),
        .irq     (irq)
    );

    always #5 aclk = ~aclk;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    bit            m_ovf, m_unf, m_cap;
    int unsigned   m_thresh, m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sext(input logic [DW-1:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s     = '0;
        s[31] = m_ovf;
        s[30] = m_unf;
        s[10:0] = 11'(q.size());
        return s;
    endfunction

    function automatic logic [31:0] m_dropcnt();
`ifdef ADS_FIFO_DROPCNT_EN
        return m_drop;
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_push(input logic [DW-1:0] v);
        if (!m_cap) m_drop++;
        else if (q.size() < DEPTH) q.push_back(v);
        else begin
            m_ovf = 1'b1;
            m_drop++;
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0; m_unf = 0; m_cap = 0; m_thresh = 0; m_drop = 0;
    endtask

    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data);
        int n;
        @(negedge aclk);
        s_axi.awaddr = addr; s_axi.awvalid = 1'b1;
        s_axi.wdata = data; s_axi.wstrb = 4'hF; s_axi.wvalid = 1'b1;
        #1;
        n = 0;
        while (!(s_axi.awready && s_axi.wready) && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        chk("aw_handshake", 32'(s_axi.awready && s_axi.wready), 32'd1);
        @(posedge aclk); #1;
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b1;
        chk("bvalid", 32'(s_axi.bvalid), 32'd1);
        @(posedge aclk); #1;
        s_axi.bready = 1'b0;
        case (addr)
            6'h04: begin
                if (data[31]) m_ovf = 0;
                if (data[30]) m_unf = 0;
            end
            6'h0C: m_thresh = 32'(data[10:0]);
            6'h20: begin
                m_cap = data[0];
                if (data[1]) begin
                    q.delete(); m_ovf = 0; m_unf = 0; m_drop = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, output logic [31:0] data);
        int n;
        @(negedge aclk);
        s_axi.araddr = addr; s_axi.arvalid = 1'b1;
        #1;
        n = 0;
        while (!s_axi.arready && n < 20) begin
            @(negedge aclk); #1; n++;
        end
        chk("ar_handshake", 32'(s_axi.arready), 32'd1);
        @(posedge aclk); #1;
        s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        chk("rvalid", 32'(s_axi.rvalid), 32'd1);
        data = s_axi.rdata;
        @(posedge aclk); #1;
        s_axi.rready = 1'b0;
    endtask

    task automatic read_chk(input logic [AW-1:0] addr, input string tag, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        chk(tag, d, exp);
    endtask

    task automatic pop_chk(input string tag);
        logic [31:0] exp;
        if (q.size() > 0) exp = sext(q.pop_front());
        else begin
            exp   = 32'd0;
            m_unf = 1'b1;
        end
        read_chk(6'h00, tag, exp);
    endtask

    task automatic push_value(input logic [DW-1:0] v);
        @(negedge aclk);
        s_data = v; s_valid = 1'b1;
        model_push(v);
        @(negedge aclk);
        s_valid = 1'b0;
    endtask

    task automatic push_burst(input int n);
        @(negedge aclk);
        for (int i = 0; i < n; i++) begin
            s_data = DW'($urandom); s_valid = 1'b1;
            model_push(s_data);
            @(negedge aclk);
        end
        s_valid = 1'b0;
    endtask

    task automatic irq_chk(input string tag);
        repeat (2) @(negedge aclk);
        chk(tag, 32'(irq), 32'((m_thresh != 0) && (q.size() >= m_thresh)));
    endtask

    initial begin
        logic [DW-1:0] v;
        logic [31:0]   exp;
        areset = 1'b1; s_valid = 1'b0; s_data = '0;
        s_axi.awaddr = '0; s_axi.awvalid = 0; s_axi.wdata = '0; s_axi.wstrb = '0;
        s_axi.wvalid = 0; s_axi.bready = 0; s_axi.araddr = '0; s_axi.arvalid = 0;
        s_axi.rready = 0;
        model_reset();
        repeat (3) @(negedge aclk);
        chk("rst_bvalid", 32'(s_axi.bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_axi.rvalid), 32'd0);
        chk("rst_rdata", s_axi.rdata, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        areset = 1'b0;
        read_chk(6'h04, "rst_status", 32'd0);
        read_chk(6'h20, "rst_ctrl", 32'd0);
        read_chk(6'h0C, "rst_thresh", 32'd0);

        // Threshold interrupt
        axi_write(6'h20, 32'd1);
        axi_write(6'h0C, 32'd512);
        push_burst(511);
        irq_chk("irq_below");
        read_chk(6'h04, "status_511", m_status());
        push_burst(1);
        irq_chk("irq_at");
        for (int i = 0; i < 512; i++) pop_chk("drain_data");
        irq_chk("irq_drained");

        // Sign extension
        push_value(24'h800001);
        push_value(24'h7FFFFF);
        read_chk(6'h00, "sext_neg", 32'hFF800001);
        read_chk(6'h00, "sext_pos", 32'h007FFFFF);
        void'(q.pop_front()); void'(q.pop_front());
        read_chk(6'h04, "status_empty", m_status());

        // Underflow and W1C
        pop_chk("unf_data");
        read_chk(6'h04, "status_unf", m_status());
        axi_write(6'h04, 32'h4000_0000);
        read_chk(6'h04, "status_unf_clr", m_status());

        // Overflow
        push_burst(DEPTH + 3);
        read_chk(6'h04, "status_ovf", m_status());
        read_chk(6'h10, "dropcnt_3", m_dropcnt());
        irq_chk("irq_full");
        axi_write(6'h04, 32'h8000_0000);
        read_chk(6'h04, "status_ovf_clr", m_status());

        // Simultaneous push and pop while full
        @(negedge aclk);
        v = DW'($urandom);
        s_data = v; s_valid = 1'b1; s_axi.araddr = 6'h00; s_axi.arvalid = 1'b1;
        #1;
        chk("simul_arready", 32'(s_axi.arready), 32'd1);
        @(posedge aclk); #1;
        s_valid = 1'b0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b1;
        exp = sext(q.pop_front());
        q.push_back(v);
        chk("simul_data", s_axi.rdata, exp);
        @(posedge aclk); #1;
        s_axi.rready = 1'b0;
        read_chk(6'h04, "status_simul", m_status());

        // Flush
        axi_write(6'h20, 32'd3);
        read_chk(6'h04, "status_flush", m_status());
        irq_chk("irq_flush");
        read_chk(6'h20, "ctrl_flush", 32'd1);
        read_chk(6'h10, "dropcnt_flush", m_dropcnt());

        // Capture disabled
        axi_write(6'h20, 32'd0);
        push_burst(5);
        read_chk(6'h04, "status_nocap", m_status());
        read_chk(6'h10, "dropcnt_nocap", m_dropcnt());

        // Random mix
        axi_write(6'h20, 32'd1);
        axi_write(6'h0C, 32'd8);
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r <= 4) push_burst(int'($urandom_range(1, 8)));
            else if (r <= 7) pop_chk("rand_data");
            else if (r == 8) axi_write(6'h0C, 32'($urandom_range(0, 40)));
            else read_chk(6'h04, "rand_status", m_status());
            if (i % 10 == 0) irq_chk("rand_irq");
        end

        // Reset during pending read
        axi_write(6'h20, 32'd3);
        push_burst(100);
        read_chk(6'h04, "status_100", m_status());
        @(negedge aclk);
        s_axi.araddr = 6'h04; s_axi.arvalid = 1'b1;
        @(posedge aclk); #1;
        s_axi.arvalid = 1'b0;
        chk("pend_rvalid", 32'(s_axi.rvalid), 32'd1);
        areset = 1'b1;
        #1;
        chk("arst_rvalid", 32'(s_axi.rvalid), 32'd0);
        chk("arst_rdata", s_axi.rdata, 32'd0);
        chk("arst_irq", 32'(irq), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        model_reset();
        read_chk(6'h04, "arst_status", m_status());
        read_chk(6'h20, "arst_ctrl", 32'd0);
        read_chk(6'h0C, "arst_thresh", 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
